// File: rtl/sr_hypot_seq.sv
// HYPO execution unit: floor(sqrt(a*a + b*b)) computed on the core's shared ALU.
// Optional macro HYPO_FASTPATH_EN completes in one cycle when either operand is zero.
module sr_hypot_seq #(
    parameter logic [2:0] OP_ADD = 3'b000,
    parameter logic [2:0] OP_SUB = 3'b100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [31:0] aluResult,
    output logic [2:0]  aluOper,
    output logic [31:0] aluSrcA,
    output logic [31:0] aluSrcB,
    output logic [8:0]  result,
    output logic        ready
);
    localparam int unsigned DW   = 32;
    localparam int unsigned ACCW = 17;
    localparam int unsigned CNTW = 4;
    localparam int unsigned RESW = 9;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SQA  = 3'd1;
    localparam logic [2:0] SQB  = 3'd2;
    localparam logic [2:0] SQRT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]      state, stateNext;
    logic [7:0]      aLat, aLatNext, bLat, bLatNext;
    logic [ACCW-1:0] acc, accNext, op, opNext, res, resNext, one, oneNext;
    logic [CNTW-1:0] cnt, cntNext;
    logic [RESW-1:0] resultNext;
    logic [7:0]      sqOperand;

    // Only the low 17 bits and the borrow bit of the shared ALU are meaningful here.
    logic unusedAluBits;
    assign unusedAluBits = &{1'b0, aluResult[30:ACCW]};

    assign ready = (state == DONE);
    assign sqOperand = (state == SQB) ? bLat : aLat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            aLat   <= '0;
            bLat   <= '0;
            acc    <= '0;
            op     <= '0;
            res    <= '0;
            one    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state  <= stateNext;
            aLat   <= aLatNext;
            bLat   <= bLatNext;
            acc    <= accNext;
            op     <= opNext;
            res    <= resNext;
            one    <= oneNext;
            cnt    <= cntNext;
            result <= resultNext;
        end
    end

    always_comb begin
        stateNext  = state;
        aLatNext   = aLat;
        bLatNext   = bLat;
        accNext    = acc;
        opNext     = op;
        resNext    = res;
        oneNext    = one;
        cntNext    = cnt;
        resultNext = result;
        aluOper    = OP_ADD;
        aluSrcA    = '0;
        aluSrcB    = '0;

        case (state)
            IDLE: begin
                if (start) begin
`ifdef HYPO_FASTPATH_EN
                    if (a == 8'd0 || b == 8'd0) begin
                        resultNext = RESW'(a | b);
                        stateNext  = DONE;
                    end else
`endif
                    begin
                        aLatNext  = a;
                        bLatNext  = b;
                        accNext   = '0;
                        cntNext   = '0;
                        stateNext = SQA;
                    end
                end
            end
            // Shift-and-add squaring: one partial product per cycle, a^2 then b^2 into acc.
            SQA, SQB: begin
                aluOper = OP_ADD;
                aluSrcA = DW'(acc);
                aluSrcB = sqOperand[cnt[2:0]] ? (DW'(sqOperand) << cnt[2:0]) : '0;
                if (!start) begin
                    stateNext = IDLE;
                end else begin
                    accNext = aluResult[ACCW-1:0];
                    if (cnt == CNTW'(7)) begin
                        cntNext = '0;
                        if (state == SQA) begin
                            stateNext = SQB;
                        end else begin
                            opNext    = aluResult[ACCW-1:0];
                            resNext   = '0;
                            oneNext   = ACCW'(1) << 16;
                            stateNext = SQRT;
                        end
                    end else begin
                        cntNext = cnt + CNTW'(1);
                    end
                end
            end
            // Digit-by-digit root; a borrow in bit 31 means op < res|one.
            SQRT: begin
                aluOper = OP_SUB;
                aluSrcA = DW'(op);
                aluSrcB = DW'(res | one);
                if (!start) begin
                    stateNext = IDLE;
                end else begin
                    if (!aluResult[DW-1]) begin
                        opNext  = aluResult[ACCW-1:0];
                        resNext = (res >> 1) | one;
                    end else begin
                        resNext = res >> 1;
                    end
                    oneNext = one >> 2;
                    if (cnt == CNTW'(8)) begin
                        resultNext = resNext[RESW-1:0];
                        cntNext    = '0;
                        stateNext  = DONE;
                    end else begin
                        cntNext = cnt + CNTW'(1);
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sr_hypot_seq.sv
// Directed self-checking bench for sr_hypot_seq, with a behavioural model of the core ALU.
module tb_sr_hypot_seq;
    localparam logic [2:0] SUB = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a, b;
    logic [31:0] aluResult;
    logic [2:0]  aluOper;
    logic [31:0] aluSrcA, aluSrcB;
    logic [8:0]  result;
    logic        ready;

    int total = 0;
    int bad = 0;

`ifdef HYPO_FASTPATH_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 26;
`endif

    sr_hypot_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .aluResult(aluResult), .aluOper(aluOper), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    // Core's single-cycle ALU
    assign aluResult = (aluOper == SUB) ? (aluSrcA - aluSrcB) : (aluSrcA + aluSrcB);

    // Called just after the cycle-0 edge; returns at the negedge of the ready cycle.
    task automatic wait_ready(input int expLat, output int lat, output int subBad);
        lat = 0;
        subBad = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if ((aluOper == SUB) != (expLat == 26 && k >= 17 && k <= 25)) subBad++;
            if (ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [8:0] expRes,
                          input int expLat, input string nm, input bit hold);
        int lat, subBad;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1 a = ~av; b = ~bv;
        wait_ready(expLat, lat, subBad);
        total++;
        if (lat !== expLat) begin
            bad++;
            $display("FAIL %s_latency: got %0d expected %0d", nm, lat, expLat);
        end
        total++;
        if (result !== expRes) begin
            bad++;
            $display("FAIL %s_result: got %0d expected %0d", nm, result, expRes);
        end
        total++;
        if (subBad !== 0) begin
            bad++;
            $display("FAIL %s_aluOper: got %0d wrong-op cycles expected 0", nm, subBad);
        end
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
            total++;
            if (ready !== 1'b0 || result !== expRes) begin
                bad++;
                $display("FAIL %s_pulse: got ready=%0b result=%0d expected ready=0 result=%0d",
                         nm, ready, result, expRes);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++;
        if (ready !== 1'b0 || result !== 9'd0 || aluOper !== 3'd0 || aluSrcA !== 32'd0 || aluSrcB !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%0b result=%0d op=%0d srcA=%0d srcB=%0d expected all 0",
                     ready, result, aluOper, aluSrcA, aluSrcB);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(8'd3, 8'd4, 9'd5, 26, "hyp_3_4", 1'b0);
        run_op(8'd255, 8'd255, 9'd360, 26, "hyp_255_255", 1'b0);
        run_op(8'd0, 8'd200, 9'd200, ZLAT, "hyp_0_200", 1'b0);
        run_op(8'd0, 8'd0, 9'd0, ZLAT, "hyp_0_0", 1'b0);
    endtask

    task automatic test_back_to_back();
        int lat, subBad;
        run_op(8'd1, 8'd1, 9'd1, 26, "b2b_first", 1'b1);
        a = 8'd6; b = 8'd8;
        @(negedge clk);
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: got ready=%0b expected 0", ready);
        end
        @(posedge clk);
        #1 a = 8'd0; b = 8'd0;
        wait_ready(26, lat, subBad);
        total++;
        if (lat + 27 !== 53) begin
            bad++;
            $display("FAIL b2b_second_cycle: got %0d expected 53", lat + 27);
        end
        total++;
        if (result !== 9'd10) begin
            bad++;
            $display("FAIL b2b_second_result: got %0d expected 10", result);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int pulses = 0;
        @(negedge clk);
        a = 8'd5; b = 8'd12; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        start = 1'b0;
        @(negedge clk);
        total++;
        if (aluOper !== 3'd0 || aluSrcA !== 32'd0 || aluSrcB !== 32'd0) begin
            bad++;
            $display("FAIL abort_idle: got op=%0d srcA=%0d srcB=%0d expected 0/0/0", aluOper, aluSrcA, aluSrcB);
        end
        repeat (30) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses);
        end
        total++;
        if (result !== 9'd10) begin
            bad++;
            $display("FAIL abort_result_held: got %0d expected 10", result);
        end
        run_op(8'd5, 8'd12, 9'd13, 26, "abort_restart", 1'b0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a = 8'd255; b = 8'd255; start = 1'b1;
        @(posedge clk);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0 || result !== 9'd0 || aluOper !== 3'd0 || aluSrcA !== 32'd0 || aluSrcB !== 32'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got ready=%0b result=%0d op=%0d srcA=%0d srcB=%0d expected all 0",
                     ready, result, aluOper, aluSrcA, aluSrcB);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd3, 8'd4, 9'd5, 26, "after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
